// File: rtl/sc_pkg.sv
// ============================================================================
// Module      : sc_pkg
// Description : Shared stochastic-computing constants and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sc_pkg;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  // Reverses the low 'width' bits of value; bits above 'width' come back as 0.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(width)) begin
        r[i] = value[5'(int'(width) - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alaghi_adder.sv
// ============================================================================
// Module      : alaghi_adder
// Description : Correlated stochastic adder; a toggle flop splits disagreeing bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alaghi_adder #(
  parameter bit reset_seed = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
  output logic z
);

  logic r_toggle;

  // Agreeing bits pass straight through; disagreeing ones alternate 0/1 from the seed.
  assign z = (x == y) ? x : r_toggle;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_toggle <= reset_seed;
    end else if (x != y) begin
      r_toggle <= ~r_toggle;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sc_sng.sv
// ============================================================================
// Module      : sc_sng
// Description : Comparator stochastic number source: stream_bit = src < value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_sng #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] value,
  output logic             stream_bit
);

  assign stream_bit = (src < value);

endmodule

`default_nettype wire

// File: rtl/sc_add_sequencer.sv
// ============================================================================
// Module      : sc_add_sequencer
// Description : Runs alaghi_adder over a full 2^WIDTH stream and returns the count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_add_sequencer
  import sc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit ADDER_SEED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             sum_bit
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH:0]   r_ones;

  logic [WIDTH-1:0] w_cnt_rev;
  logic             w_run;
  logic             w_cnt_last;
  logic             w_x_raw;
  logic             w_y_raw;
  logic             w_x;
  logic             w_y;
  logic             w_z;
  logic             w_adder_rst;

  assign w_run      = (r_state == c_RUN);
  assign w_cnt_last = (r_cnt == {WIDTH{1'b1}});
  assign w_cnt_rev  = WIDTH'(bitrev(32'(r_cnt), WIDTH));

  sc_sng #(.WIDTH(WIDTH)) u_sng_x (
    .src        (r_cnt),
    .value      (r_a),
    .stream_bit (w_x_raw)
  );

  // Bit-reversed source keeps the y stream decorrelated from the thermometer x stream.
  sc_sng #(.WIDTH(WIDTH)) u_sng_y (
    .src        (w_cnt_rev),
    .value      (r_b),
    .stream_bit (w_y_raw)
  );

  assign w_x         = w_run & w_x_raw;
  assign w_y         = w_run & w_y_raw;
  assign w_adder_rst = rst | (r_state == c_LOAD);

  alaghi_adder #(.reset_seed(ADDER_SEED)) u_adder (
    .clk (clk),
    .rst (w_adder_rst),
    .x   (w_x),
    .y   (w_y),
    .z   (w_z)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_ones  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_state <= c_LOAD;
          end
        end
        c_LOAD: begin
          r_cnt   <= '0;
          r_ones  <= '0;
          r_state <= c_RUN;
        end
        c_RUN: begin
          r_ones <= r_ones + (WIDTH+1)'(w_z);
          r_cnt  <= r_cnt + 1'b1;
          if (w_cnt_last) begin
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // The sum of two sub-unity probabilities halved can never reach 2^WIDTH ones.
  always_ff @(posedge clk) begin
    if (!rst && r_state == c_DONE) begin
      assert (r_ones[WIDTH] == 1'b0);
    end
  end

  assign in_ready  = (r_state == c_IDLE);
  assign out_valid = (r_state == c_DONE);
  assign result    = r_ones[WIDTH-1:0];
  assign busy      = (r_state == c_LOAD) || w_run;
  assign sum_bit   = w_run & w_z;

endmodule

`default_nettype wire

// File: tb/tb_sc_add_sequencer.sv
// ============================================================================
// Module      : tb_sc_add_sequencer
// Description : Directed and random checks of sc_add_sequencer, both seeds in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_add_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  logic             in_ready0, out_valid0, busy0, sum_bit0;
  logic             in_ready1, out_valid1, busy1, sum_bit1;
  logic [WIDTH-1:0] result0, result1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sc_add_sequencer #(.WIDTH(WIDTH), .ADDER_SEED(1'b0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .a         (a),
    .b         (b),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .result    (result0),
    .busy      (busy0),
    .sum_bit   (sum_bit0)
  );

  sc_add_sequencer #(.WIDTH(WIDTH), .ADDER_SEED(1'b1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .a         (a),
    .b         (b),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .result    (result1),
    .busy      (busy1),
    .sum_bit   (sum_bit1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full transaction; hold = cycles out_ready stays low in DONE while in_valid is pulsed.
  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input int hold,
                        output logic [WIDTH-1:0] r0, output logic [WIDTH-1:0] r1,
                        output int lat, output int busy_n, output int sum_n);
    int guard;
    guard  = 0;
    busy_n = 0;
    sum_n  = 0;
    while (!in_ready0 && guard < 600) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 600) check("in_ready_timeout", 32'd0, 32'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid0 && lat < 600) begin
      if (busy0) busy_n++;
      if (sum_bit0) sum_n++;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid0) check("out_valid_timeout", 32'd0, 32'd1);
    r0 = result0;
    r1 = result1;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      a = ~va;
      b = ~vb;
      @(posedge clk); #1;
      check("hold_result", 32'(result0), 32'(r0));
      check("hold_out_valid", 32'(out_valid0), 32'd1);
      check("hold_in_ready", 32'(in_ready0), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_handshake", 32'(in_ready0), 32'd1);
    check("out_valid_after_handshake", 32'(out_valid0 | out_valid1), 32'd0);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] r0, r1, va, vb;
    int lat, busy_n, sum_n, seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready0), 32'd1);
    check("reset_out_valid", 32'(out_valid0), 32'd0);
    check("reset_result", 32'(result0), 32'd0);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_sum_bit", 32'(sum_bit0), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'd100, 8'd50, 0, r0, r1, lat, busy_n, sum_n);
    check("100+50_seed0", 32'(r0), 32'd75);
    check("100+50_seed1", 32'(r1), 32'd75);
    check("latency", 32'(lat), 32'd258);
    check("busy_cycles", 32'(busy_n), 32'd257);
    check("100+50_stream_ones", 32'(sum_n), 32'd75);

    run_op(8'd3, 8'd0, 0, r0, r1, lat, busy_n, sum_n);
    check("3+0_seed0", 32'(r0), 32'd1);
    check("3+0_seed1", 32'(r1), 32'd2);
    check("3+0_stream_ones", 32'(sum_n), 32'd1);

    run_op(8'd255, 8'd255, 0, r0, r1, lat, busy_n, sum_n);
    check("255+255_seed0", 32'(r0), 32'd255);
    check("255+255_seed1", 32'(r1), 32'd255);
    check("255+255_stream_ones", 32'(sum_n), 32'd255);

    run_op(8'd0, 8'd0, 0, r0, r1, lat, busy_n, sum_n);
    check("0+0_seed0", 32'(r0), 32'd0);
    check("0+0_seed1", 32'(r1), 32'd0);
    check("0+0_sum_bit_zero", 32'(sum_n), 32'd0);

    run_op(8'd60, 8'd71, 20, r0, r1, lat, busy_n, sum_n);
    check("60+71_hold_seed0", 32'(r0), 32'd65);
    check("60+71_hold_seed1", 32'(r1), 32'd66);

    // Abort a run partway through the stream.
    a = 8'd200;
    b = 8'd100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (101) @(posedge clk);
    #1;
    check("busy_before_abort", 32'(busy0), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready0), 32'd1);
    check("abort_out_valid", 32'(out_valid0), 32'd0);
    check("abort_busy", 32'(busy0), 32'd0);
    seen = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (out_valid0 || out_valid1) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);

    run_op(8'd10, 8'd20, 0, r0, r1, lat, busy_n, sum_n);
    check("10+20_seed0", 32'(r0), 32'd15);
    check("10+20_seed1", 32'(r1), 32'd15);

    for (int k = 0; k < 200; k++) begin
      va = 8'($urandom_range(0, 255));
      vb = 8'($urandom_range(0, 255));
      run_op(va, vb, int'($urandom_range(0, 3)), r0, r1, lat, busy_n, sum_n);
      check("rand_seed0", 32'(r0), (32'(va) + 32'(vb)) >> 1);
      check("rand_seed1", 32'(r1), (32'(va) + 32'(vb) + 32'd1) >> 1);
      check("rand_latency", 32'(lat), 32'd258);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
